// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A-style command sequencer:
// state enums, OCW2 command codes, register field positions and the config register layout.
package pic_pkg;

   typedef enum logic [2:0] {
      S_ICW1,
      S_ICW2,
      S_ICW3,
      S_ICW4,
      S_READY
   } cfg_state_t;

   typedef enum logic [1:0] {
      I_IDLE,
      I_WAIT2,
      I_VEC
   } inta_state_t;

   // OCW2 command codes, din[7:5]
   localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
   localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
   localparam logic [2:0] OCW2_NOP          = 3'b010;
   localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
   localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
   localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
   localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
   localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

   localparam int unsigned ICW1_IC4  = 0;
   localparam int unsigned ICW1_SNGL = 1;
   localparam int unsigned ICW1_LTIM = 3;
   localparam int unsigned ICW1_SEL  = 4;
   localparam int unsigned ICW4_UPM  = 0;
   localparam int unsigned ICW4_AEOI = 1;
   localparam int unsigned ICW4_MS   = 2;
   localparam int unsigned ICW4_BUF  = 3;
   localparam int unsigned OCW3_SEL  = 3;
   localparam int unsigned OCW3_RIS  = 0;
   localparam int unsigned OCW3_RR   = 1;
   localparam int unsigned OCW3_SMM  = 5;
   localparam int unsigned OCW3_ESMM = 6;

   localparam int unsigned STROBE_CYCLES = 1;
   localparam logic [2:0]  SPURIOUS_LEVEL = 3'd7;

   typedef struct packed {
      logic [7:0] imr;
      logic [7:0] cas_cfg;
      logic [4:0] vec_base;
      logic       ltim;
      logic       sngl;
      logic       ic4;
      logic       aeoi;
      logic       ms;
      logic       buf_mode;
      logic       mode_err;
      logic       rd_sel;
      logic       smm;
      logic       rot_aeoi;
      logic       init_done;
   } pic_cfg_t;

   localparam int unsigned CFG_W = $bits(pic_cfg_t);

endpackage

// File: rtl/pic_strobe_sync.sv
// Multi-flop synchronizer for an idle-high async strobe with falling/rising edge detect.
module pic_strobe_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic fall_c,
   output logic rise_c
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign fall_c = prev_q & ~sync_q[SYNC_STAGES-1];
   assign rise_c = ~prev_q & sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pic_cmd_sequencer.sv
// ICW/OCW write decoder and 8086-mode INTA sequencer for an 8259A-style PIC.
import pic_pkg::*;

module pic_cmd_sequencer #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  MASK_RESET  = 8'hFF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ncs,
   input  logic       nwr,
   input  logic       a0,
   input  logic [7:0] din,
   input  logic       ninta,
   input  logic       irq_valid,
   input  logic [2:0] irq_level,
   output logic       init_done,
   output logic       ltim,
   output logic       sngl,
   output logic [4:0] vec_base,
   output logic [7:0] cas_cfg,
   output logic       aeoi,
   output logic       ms,
   output logic       buf_mode,
   output logic       mode_err,
   output logic [7:0] imr,
   output logic       rd_sel,
   output logic       smm,
   output logic       rot_aeoi,
   output logic       eoi_stb,
   output logic       eoi_spec,
   output logic [2:0] eoi_level,
   output logic       rot_stb,
   output logic       prio_stb,
   output logic [2:0] prio_level,
   output logic       isr_set_stb,
   output logic [2:0] isr_set_level,
   output logic       vec_oe,
   output logic [7:0] vec_out
);

   localparam pic_cfg_t CFG_RESET = pic_cfg_t'({MASK_RESET, (CFG_W-8)'(0)});

   logic wr_fall_c, wr_rise_unused, inta_fall_c, inta_rise_c;

   cfg_state_t  cstate_q, cstate_d;
   inta_state_t istate_q, istate_d;
   pic_cfg_t    cfg_q, cfg_d;

   logic       icw1_c, ocw_eoi_c, ocw_spec_c, ocw_rot_c, ocw_prio_c;
   logic       inta_en_c, aeoi_req_c, aeoi_rot_c;
   logic [2:0] lvl_q, lvl_d;
   logic       valid_q, valid_d, pend_q, pend_d, pend_rot_q, pend_rot_d;
   logic       eoi_stb_d, eoi_spec_d, rot_stb_d, prio_stb_d, isr_set_stb_d, vec_oe_d;
   logic [2:0] eoi_level_d, prio_level_d, isr_set_level_d;
   logic [7:0] vec_out_d;

   pic_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
      .clk    (clk),
      .reset  (reset),
      .d      (ncs | nwr),
      .fall_c (wr_fall_c),
      .rise_c (wr_rise_unused)
   );

   pic_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_inta_sync (
      .clk    (clk),
      .reset  (reset),
      .d      (ninta),
      .fall_c (inta_fall_c),
      .rise_c (inta_rise_c)
   );

   // Configuration FSM: ICW sequencing plus OCW decode once initialised
   always_comb begin
      cstate_d   = cstate_q;
      cfg_d      = cfg_q;
      icw1_c     = 1'b0;
      ocw_eoi_c  = 1'b0;
      ocw_spec_c = 1'b0;
      ocw_rot_c  = 1'b0;
      ocw_prio_c = 1'b0;
      if (wr_fall_c) begin
         if (!a0 && din[ICW1_SEL]) begin
            icw1_c         = 1'b1;
            cfg_d.ltim     = din[ICW1_LTIM];
            cfg_d.sngl     = din[ICW1_SNGL];
            cfg_d.ic4      = din[ICW1_IC4];
            cfg_d.imr      = 8'h00;
            cfg_d.aeoi     = 1'b0;
            cfg_d.ms       = 1'b0;
            cfg_d.buf_mode = 1'b0;
            cfg_d.rd_sel   = 1'b0;
            cfg_d.smm      = 1'b0;
            cfg_d.rot_aeoi = 1'b0;
            cfg_d.init_done = 1'b0;
            cstate_d       = S_ICW2;
         end else begin
            case (cstate_q)
               S_ICW1: ;
               S_ICW2: if (a0) begin
                  cfg_d.vec_base = din[7:3];
                  if (!cfg_q.sngl) begin
                     cstate_d = S_ICW3;
                  end else if (cfg_q.ic4) begin
                     cstate_d = S_ICW4;
                  end else begin
                     cstate_d        = S_READY;
                     cfg_d.init_done = 1'b1;
                     cfg_d.mode_err  = 1'b1;
                  end
               end
               S_ICW3: if (a0) begin
                  cfg_d.cas_cfg = din;
                  if (cfg_q.ic4) begin
                     cstate_d = S_ICW4;
                  end else begin
                     cstate_d        = S_READY;
                     cfg_d.init_done = 1'b1;
                     cfg_d.mode_err  = 1'b1;
                  end
               end
               S_ICW4: if (a0) begin
                  cfg_d.aeoi      = din[ICW4_AEOI];
                  cfg_d.ms        = din[ICW4_MS];
                  cfg_d.buf_mode  = din[ICW4_BUF];
                  cfg_d.mode_err  = ~din[ICW4_UPM];
                  cfg_d.init_done = 1'b1;
                  cstate_d        = S_READY;
               end
               S_READY: begin
                  if (a0) begin
                     cfg_d.imr = din;
                  end else if (!din[OCW3_SEL]) begin
                     case (din[7:5])
                        OCW2_NS_EOI:       ocw_eoi_c = 1'b1;
                        OCW2_SP_EOI:       {ocw_eoi_c, ocw_spec_c} = 2'b11;
                        OCW2_ROT_NS_EOI:   {ocw_eoi_c, ocw_rot_c} = 2'b11;
                        OCW2_ROT_SP_EOI:   {ocw_eoi_c, ocw_spec_c, ocw_rot_c} = 3'b111;
                        OCW2_SET_PRIO:     ocw_prio_c = 1'b1;
                        OCW2_ROT_AEOI_SET: cfg_d.rot_aeoi = 1'b1;
                        OCW2_ROT_AEOI_CLR: cfg_d.rot_aeoi = 1'b0;
                        OCW2_NOP:          ;
                        default:           ;
                     endcase
                  end else begin
                     if (din[OCW3_RR])   cfg_d.rd_sel = din[OCW3_RIS];
                     if (din[OCW3_ESMM]) cfg_d.smm    = din[OCW3_SMM];
                  end
               end
               default: cstate_d = S_ICW1;
            endcase
         end
      end
   end

   // INTA FSM and strobe merge; an AEOI colliding with an OCW2 EOI is deferred one cycle
   always_comb begin
      istate_d        = istate_q;
      lvl_d           = lvl_q;
      valid_d         = valid_q;
      vec_oe_d        = vec_oe;
      vec_out_d       = vec_out;
      isr_set_stb_d   = 1'b0;
      isr_set_level_d = isr_set_level;
      aeoi_req_c      = 1'b0;
      aeoi_rot_c      = 1'b0;
      inta_en_c       = cfg_q.init_done & ~cfg_q.mode_err;
      if (icw1_c) begin
         istate_d = I_IDLE;
         vec_oe_d = 1'b0;
      end else begin
         case (istate_q)
            I_IDLE: if (inta_fall_c && inta_en_c) begin
               lvl_d         = irq_valid ? irq_level : SPURIOUS_LEVEL;
               valid_d       = irq_valid;
               isr_set_stb_d = irq_valid;
               if (irq_valid) isr_set_level_d = irq_level;
               istate_d      = I_WAIT2;
            end
            I_WAIT2: if (inta_fall_c && inta_en_c) begin
               vec_oe_d  = 1'b1;
               vec_out_d = {cfg_q.vec_base, lvl_q};
               istate_d  = I_VEC;
            end
            I_VEC: if (inta_rise_c) begin
               vec_oe_d   = 1'b0;
               aeoi_req_c = cfg_q.aeoi & valid_q;
               aeoi_rot_c = cfg_q.rot_aeoi;
               istate_d   = I_IDLE;
            end
            default: istate_d = I_IDLE;
         endcase
      end

      eoi_stb_d    = ocw_eoi_c;
      eoi_spec_d   = ocw_spec_c;
      eoi_level_d  = ocw_spec_c ? din[2:0] : eoi_level;
      rot_stb_d    = ocw_rot_c;
      prio_stb_d   = ocw_prio_c;
      prio_level_d = ocw_prio_c ? din[2:0] : prio_level;
      pend_d       = 1'b0;
      pend_rot_d   = 1'b0;
      if (pend_q) begin
         eoi_stb_d = 1'b1;
         rot_stb_d = rot_stb_d | pend_rot_q;
      end else if (aeoi_req_c) begin
         if (ocw_eoi_c) begin
            pend_d     = 1'b1;
            pend_rot_d = aeoi_rot_c;
         end else begin
            eoi_stb_d = 1'b1;
            rot_stb_d = aeoi_rot_c;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cstate_q      <= S_ICW1;
         istate_q      <= I_IDLE;
         cfg_q         <= CFG_RESET;
         lvl_q         <= 3'd0;
         valid_q       <= 1'b0;
         pend_q        <= 1'b0;
         pend_rot_q    <= 1'b0;
         eoi_stb       <= 1'b0;
         eoi_spec      <= 1'b0;
         eoi_level     <= 3'd0;
         rot_stb       <= 1'b0;
         prio_stb      <= 1'b0;
         prio_level    <= 3'd0;
         isr_set_stb   <= 1'b0;
         isr_set_level <= 3'd0;
         vec_oe        <= 1'b0;
         vec_out       <= 8'h00;
      end else begin
         cstate_q      <= cstate_d;
         istate_q      <= istate_d;
         cfg_q         <= cfg_d;
         lvl_q         <= lvl_d;
         valid_q       <= valid_d;
         pend_q        <= pend_d;
         pend_rot_q    <= pend_rot_d;
         eoi_stb       <= eoi_stb_d;
         eoi_spec      <= eoi_spec_d;
         eoi_level     <= eoi_level_d;
         rot_stb       <= rot_stb_d;
         prio_stb      <= prio_stb_d;
         prio_level    <= prio_level_d;
         isr_set_stb   <= isr_set_stb_d;
         isr_set_level <= isr_set_level_d;
         vec_oe        <= vec_oe_d;
         vec_out       <= vec_out_d;
      end
   end

   assign init_done = cfg_q.init_done;
   assign ltim      = cfg_q.ltim;
   assign sngl      = cfg_q.sngl;
   assign vec_base  = cfg_q.vec_base;
   assign cas_cfg   = cfg_q.cas_cfg;
   assign aeoi      = cfg_q.aeoi;
   assign ms        = cfg_q.ms;
   assign buf_mode  = cfg_q.buf_mode;
   assign mode_err  = cfg_q.mode_err;
   assign imr       = cfg_q.imr;
   assign rd_sel    = cfg_q.rd_sel;
   assign smm       = cfg_q.smm;
   assign rot_aeoi  = cfg_q.rot_aeoi;

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Bench for pic_cmd_sequencer: table of CPU writes with expected register state, and a
// strobe scoreboard fed by hand-written INTA / abort / reset sequences.
module tb_pic_cmd_sequencer;

   typedef struct packed {
      logic       init_done, ltim, sngl;
      logic [4:0] vec_base;
      logic [7:0] cas_cfg;
      logic       aeoi, ms, buf_mode, mode_err;
      logic [7:0] imr;
      logic       rd_sel, smm, rot_aeoi;
   } st_t;

   typedef struct packed {
      logic       eoi, spec, rot, prio, isr;
      logic [2:0] lvl;
   } ev_t;

   typedef struct {
      logic       a0;
      logic [7:0] din;
      logic       has_ev;
      ev_t        ev;
      st_t        st;
   } vec_t;

   logic clk = 1'b0;
   logic reset, ncs, nwr, a0, ninta, irq_valid;
   logic [7:0] din;
   logic [2:0] irq_level;
   logic init_done, ltim, sngl, aeoi, ms, buf_mode, mode_err, rd_sel, smm, rot_aeoi;
   logic [4:0] vec_base;
   logic [7:0] cas_cfg, imr, vec_out;
   logic eoi_stb, eoi_spec, rot_stb, prio_stb, isr_set_stb, vec_oe;
   logic [2:0] eoi_level, prio_level, isr_set_level;

   int checks = 0;
   int passes = 0;
   int rd_idx = 0;
   ev_t act_q[$];
   ev_t exp_q[$];
   vec_t tbl[$];
   localparam ev_t NOEV = '0;

   always #5 clk = ~clk;

   pic_cmd_sequencer dut (
      .clk(clk), .reset(reset), .ncs(ncs), .nwr(nwr), .a0(a0), .din(din),
      .ninta(ninta), .irq_valid(irq_valid), .irq_level(irq_level),
      .init_done(init_done), .ltim(ltim), .sngl(sngl), .vec_base(vec_base),
      .cas_cfg(cas_cfg), .aeoi(aeoi), .ms(ms), .buf_mode(buf_mode),
      .mode_err(mode_err), .imr(imr), .rd_sel(rd_sel), .smm(smm),
      .rot_aeoi(rot_aeoi), .eoi_stb(eoi_stb), .eoi_spec(eoi_spec),
      .eoi_level(eoi_level), .rot_stb(rot_stb), .prio_stb(prio_stb),
      .prio_level(prio_level), .isr_set_stb(isr_set_stb),
      .isr_set_level(isr_set_level), .vec_oe(vec_oe), .vec_out(vec_out)
   );

   // Record every strobe cycle the DUT produces
   always @(negedge clk) begin
      if (eoi_stb | rot_stb | prio_stb | isr_set_stb)
         act_q.push_back('{eoi_stb, eoi_spec, rot_stb, prio_stb, isr_set_stb,
                           isr_set_stb ? isr_set_level :
                           prio_stb ? prio_level :
                           eoi_spec ? eoi_level : 3'd0});
   end

   function automatic st_t mk_st(logic ini, logic lt, logic sg, logic [4:0] vb, logic [7:0] cs,
                                 logic ae, logic m, logic bf, logic me, logic [7:0] im,
                                 logic rd, logic sm, logic ra);
      return '{ini, lt, sg, vb, cs, ae, m, bf, me, im, rd, sm, ra};
   endfunction

   function automatic ev_t mk_ev(logic e, logic sp, logic r, logic p, logic i, logic [2:0] l);
      return '{e, sp, r, p, i, l};
   endfunction

   function automatic st_t cur_st();
      return '{init_done, ltim, sngl, vec_base, cas_cfg, aeoi, ms, buf_mode, mode_err,
               imr, rd_sel, smm, rot_aeoi};
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(logic a, logic [7:0] d);
      a0 = a; din = d; ncs = 1'b0; nwr = 1'b0;
      tick(5);
      ncs = 1'b1; nwr = 1'b1;
      tick(5);
   endtask

   task automatic inta_pulse();
      ninta = 1'b0; tick(5);
      ninta = 1'b1; tick(5);
   endtask

   // Match expected strobes against recorded ones, flag missing and extra events
   task automatic drain(string nm);
      ev_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rd_idx < act_q.size()) begin
            chk({nm, "_strobe"}, 64'(act_q[rd_idx]), 64'(e));
            rd_idx++;
         end else begin
            checks++;
            $display("FAIL %s_strobe missing actual=none required=%0h", nm, e);
         end
      end
      while (rd_idx < act_q.size()) begin
         checks++;
         $display("FAIL %s_strobe unexpected actual=%0h required=none", nm, act_q[rd_idx]);
         rd_idx++;
      end
   endtask

   task automatic add(logic a, logic [7:0] d, logic h, ev_t e, st_t s);
      vec_t v;
      v.a0 = a; v.din = d; v.has_ev = h; v.ev = e; v.st = s;
      tbl.push_back(v);
   endtask

   initial begin
      reset = 1'b1; ncs = 1'b1; nwr = 1'b1; a0 = 1'b0; din = 8'h00;
      ninta = 1'b1; irq_valid = 1'b0; irq_level = 3'd0;

      //   a0 din    ev?  event                          ini lt sg vb     cas    ae ms bf me imr    rd sm ra
      add(0, 8'h13, 0, NOEV,                      mk_st(0, 0, 1, 5'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0));
      add(1, 8'h48, 0, NOEV,                      mk_st(0, 0, 1, 5'h09, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0));
      add(1, 8'h01, 0, NOEV,                      mk_st(1, 0, 1, 5'h09, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0));
      add(0, 8'h11, 0, NOEV,                      mk_st(0, 0, 0, 5'h09, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0));
      add(1, 8'h20, 0, NOEV,                      mk_st(0, 0, 0, 5'h04, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0));
      add(1, 8'h04, 0, NOEV,                      mk_st(0, 0, 0, 5'h04, 8'h04, 0, 0, 0, 0, 8'h00, 0, 0, 0));
      add(1, 8'h03, 0, NOEV,                      mk_st(1, 0, 0, 5'h04, 8'h04, 1, 0, 0, 0, 8'h00, 0, 0, 0));
      add(1, 8'hF0, 0, NOEV,                      mk_st(1, 0, 0, 5'h04, 8'h04, 1, 0, 0, 0, 8'hF0, 0, 0, 0));
      add(0, 8'h63, 1, mk_ev(1, 1, 0, 0, 0, 3'd3), mk_st(1, 0, 0, 5'h04, 8'h04, 1, 0, 0, 0, 8'hF0, 0, 0, 0));
      add(0, 8'hC5, 1, mk_ev(0, 0, 0, 1, 0, 3'd5), mk_st(1, 0, 0, 5'h04, 8'h04, 1, 0, 0, 0, 8'hF0, 0, 0, 0));
      add(0, 8'h0B, 0, NOEV,                      mk_st(1, 0, 0, 5'h04, 8'h04, 1, 0, 0, 0, 8'hF0, 1, 0, 0));
      add(0, 8'h68, 0, NOEV,                      mk_st(1, 0, 0, 5'h04, 8'h04, 1, 0, 0, 0, 8'hF0, 1, 1, 0));
      add(0, 8'h80, 0, NOEV,                      mk_st(1, 0, 0, 5'h04, 8'h04, 1, 0, 0, 0, 8'hF0, 1, 1, 1));
      add(0, 8'hA0, 1, mk_ev(1, 0, 1, 0, 0, 3'd0), mk_st(1, 0, 0, 5'h04, 8'h04, 1, 0, 0, 0, 8'hF0, 1, 1, 1));
      add(0, 8'hE6, 1, mk_ev(1, 1, 1, 0, 0, 3'd6), mk_st(1, 0, 0, 5'h04, 8'h04, 1, 0, 0, 0, 8'hF0, 1, 1, 1));
      add(0, 8'h20, 1, mk_ev(1, 0, 0, 0, 0, 3'd0), mk_st(1, 0, 0, 5'h04, 8'h04, 1, 0, 0, 0, 8'hF0, 1, 1, 1));
      add(0, 8'h40, 0, NOEV,                      mk_st(1, 0, 0, 5'h04, 8'h04, 1, 0, 0, 0, 8'hF0, 1, 1, 1));
      add(0, 8'h00, 0, NOEV,                      mk_st(1, 0, 0, 5'h04, 8'h04, 1, 0, 0, 0, 8'hF0, 1, 1, 0));
      add(0, 8'h1B, 0, NOEV,                      mk_st(0, 1, 1, 5'h04, 8'h04, 0, 0, 0, 0, 8'h00, 0, 0, 0));
      add(0, 8'h08, 0, NOEV,                      mk_st(0, 1, 1, 5'h04, 8'h04, 0, 0, 0, 0, 8'h00, 0, 0, 0));
      add(1, 8'h48, 0, NOEV,                      mk_st(0, 1, 1, 5'h09, 8'h04, 0, 0, 0, 0, 8'h00, 0, 0, 0));
      add(1, 8'h0F, 0, NOEV,                      mk_st(1, 1, 1, 5'h09, 8'h04, 1, 1, 1, 0, 8'h00, 0, 0, 0));
      add(0, 8'h80, 0, NOEV,                      mk_st(1, 1, 1, 5'h09, 8'h04, 1, 1, 1, 0, 8'h00, 0, 0, 1));

      tick(3);
      chk("reset_status", 64'(cur_st()),
          64'(mk_st(0, 0, 0, 5'h00, 8'h00, 0, 0, 0, 0, 8'hFF, 0, 0, 0)));
      chk("reset_strobes", 64'({eoi_stb, eoi_spec, rot_stb, prio_stb, isr_set_stb, vec_oe, vec_out}), 64'(0));
      reset = 1'b0;
      tick(2);

      foreach (tbl[i]) begin
         if (tbl[i].has_ev) exp_q.push_back(tbl[i].ev);
         wr(tbl[i].a0, tbl[i].din);
         chk($sformatf("row%0d_status", i), 64'(cur_st()), 64'(tbl[i].st));
         drain($sformatf("row%0d", i));
      end

      // Valid request, AEOI with rotate; irq_valid drops between pulses
      irq_valid = 1'b1; irq_level = 3'd2;
      exp_q.push_back(mk_ev(0, 0, 0, 0, 1, 3'd2));
      inta_pulse();
      drain("inta_valid_p1");
      irq_valid = 1'b0;
      exp_q.push_back(mk_ev(1, 0, 1, 0, 0, 3'd0));
      ninta = 1'b0; tick(5);
      chk("inta_valid_vec", 64'({vec_oe, vec_out}), 64'({1'b1, 8'h4A}));
      ninta = 1'b1; tick(5);
      chk("inta_valid_release", 64'({vec_oe, vec_out}), 64'({1'b0, 8'h4A}));
      drain("inta_valid_p2");

      // Spurious request: level 7, no ISR set, no AEOI
      irq_valid = 1'b0;
      inta_pulse();
      drain("inta_spur_p1");
      ninta = 1'b0; tick(5);
      chk("inta_spur_vec", 64'({vec_oe, vec_out}), 64'({1'b1, 8'h4F}));
      ninta = 1'b1; tick(5);
      drain("inta_spur_p2");

      // ICW1 between the two pulses aborts the acknowledge
      irq_valid = 1'b1; irq_level = 3'd4;
      exp_q.push_back(mk_ev(0, 0, 0, 0, 1, 3'd4));
      inta_pulse();
      drain("abort_p1");
      wr(0, 8'h13);
      ninta = 1'b0; tick(5);
      chk("abort_vec_oe", 64'({vec_oe, init_done}), 64'(0));
      ninta = 1'b1; tick(5);
      drain("abort_p2");
      wr(1, 8'h48);
      wr(1, 8'h01);
      irq_level = 3'd1;
      exp_q.push_back(mk_ev(0, 0, 0, 0, 1, 3'd1));
      inta_pulse();
      drain("abort_idle_p1");
      ninta = 1'b0; tick(5);
      chk("abort_idle_vec", 64'({vec_oe, vec_out}), 64'({1'b1, 8'h49}));
      ninta = 1'b1; tick(5);
      drain("abort_idle_p2");

      // No ICW4 requested: 8080 mode flagged, INTA ignored
      wr(0, 8'h12);
      wr(1, 8'h48);
      chk("mode_err_flags", 64'({init_done, mode_err, aeoi}), 64'(3'b110));
      irq_level = 3'd3;
      inta_pulse();
      ninta = 1'b0; tick(5);
      chk("mode_err_vec_oe", 64'(vec_oe), 64'(0));
      ninta = 1'b1; tick(5);
      drain("mode_err");

      // Reset in the middle of an acknowledge sequence
      wr(0, 8'h13);
      wr(1, 8'h48);
      wr(1, 8'h01);
      wr(1, 8'h55);
      chk("pre_reset_imr", 64'(imr), 64'(8'h55));
      exp_q.push_back(mk_ev(0, 0, 0, 0, 1, 3'd3));
      inta_pulse();
      drain("mid_reset_p1");
      reset = 1'b1;
      #2;
      chk("mid_reset_status", 64'(cur_st()),
          64'(mk_st(0, 0, 0, 5'h00, 8'h00, 0, 0, 0, 0, 8'hFF, 0, 0, 0)));
      chk("mid_reset_strobes", 64'({eoi_stb, rot_stb, prio_stb, isr_set_stb, vec_oe}), 64'(0));
      tick(2);
      reset = 1'b0;
      tick(2);
      ninta = 1'b0; tick(5);
      chk("post_reset_vec_oe", 64'(vec_oe), 64'(0));
      ninta = 1'b1; tick(5);
      drain("post_reset");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/pic_cmd_sequencer.md
Name: pic_cmd_sequencer

Overview:
- Clocked command and interrupt-acknowledge controller for the 8259A-style PIC.
- Decodes CPU writes (ICW1–ICW4, OCW1–OCW3) into configuration registers and single-cycle command strobes for the IRR/ISR/priority datapath.
- Sequences the two-pulse INTA cycle in 8086 mode: sets ISR, drives the vector, issues AEOI.
- Sits between the read/write bus logic and the priority resolver / in-service register.

Parameters:
- SYNC_STAGES, 2, flops in each strobe synchronizer (minimum 2).
- MASK_RESET, 8'hFF, imr value after reset (before ICW1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ncs  in  1  chip select, active low
- nwr  in  1  write strobe, active low
- a0  in  1  register address bit
- din  in  8  CPU write data
- ninta  in  1  interrupt acknowledge, active low
- irq_valid  in  1  resolver has an unmasked pending request
- irq_level  in  3  highest-priority pending level
- init_done  out  1  ICW sequence complete
- ltim  out  1  level-triggered mode (ICW1 bit 3)
- sngl  out  1  single mode (ICW1 bit 1)
- vec_base  out  5  ICW2 bits 7:3
- cas_cfg  out  8  ICW3 byte
- aeoi  out  1  ICW4 bit 1
- ms  out  1  ICW4 bit 2
- buf_mode  out  1  ICW4 bit 3
- mode_err  out  1  8080 mode selected (unsupported)
- imr  out  8  interrupt mask (OCW1)
- rd_sel  out  1  0 = IRR, 1 = ISR readback
- smm  out  1  special mask mode
- rot_aeoi  out  1  rotate on AEOI
- eoi_stb  out  1  EOI pulse
- eoi_spec  out  1  qualifies eoi_stb as specific
- eoi_level  out  3  specific EOI level
- rot_stb  out  1  rotate priority pulse
- prio_stb  out  1  set-lowest-priority pulse
- prio_level  out  3  level for prio_stb
- isr_set_stb  out  1  set ISR bit pulse
- isr_set_level  out  3  level for isr_set_stb
- vec_oe  out  1  drive vec_out onto the data bus
- vec_out  out  8  interrupt vector

Behaviour:
- Reset state:
  - Every output is 0, except imr = MASK_RESET.
  - Configuration FSM = S_ICW1; INTA FSM = I_IDLE.
- Synchronization:
  - Write strobe w = ncs|nwr and ninta each pass through SYNC_STAGES flops plus a falling-edge detector.
  - A write is accepted in the cycle the synchronized w is first low.
  - a0/din are sampled in that same cycle; the bus must be held stable for at least SYNC_STAGES+1 cycles of the low strobe.
  - Register and strobe updates appear on the next clock.
- Strobes are exactly 1 cycle wide. Each is asserted only in the cycle after its triggering edge.
- Configuration FSM, states S_ICW1, S_ICW2, S_ICW3, S_ICW4, S_READY:
  - ICW1 (a0=0, din[4]=1), accepted in any state:
    - ltim=din[3], sngl=din[1]; store ic4=din[0].
    - imr=0, aeoi=ms=buf_mode=0, rd_sel=0, smm=0, rot_aeoi=0, init_done=0.
    - INTA FSM aborts to I_IDLE.
    - Next state S_ICW2.
  - S_ICW1: all other writes ignored.
  - S_ICW2, on an a0=1 write:
    - vec_base=din[7:3].
    - Next state: S_ICW3 if !sngl, else S_ICW4 if ic4, else S_READY.
  - S_ICW3, on an a0=1 write: cas_cfg=din; next S_ICW4 if ic4, else S_READY.
  - S_ICW4, on an a0=1 write: aeoi=din[1], ms=din[2], buf_mode=din[3]; mode_err=~din[0]; next S_READY.
  - Entering S_READY with ic4=0 sets mode_err=1.
  - In S_ICW2–S_ICW4, a0=0 non-ICW1 writes are ignored.
  - S_READY: init_done=1.
    - a0=1: imr=din (OCW1).
    - a0=0 with din[4:3]=00: OCW2.
    - a0=0 with din[4:3]=01: OCW3.
- OCW2 decode on din[7:5]:
  - 001: eoi_stb.
  - 011: eoi_stb, eoi_spec, eoi_level=din[2:0].
  - 101: eoi_stb, rot_stb.
  - 111: eoi_stb, eoi_spec, rot_stb, eoi_level=din[2:0].
  - 110: prio_stb, prio_level=din[2:0].
  - 100: rot_aeoi=1.
  - 000: rot_aeoi=0.
  - 010: no-op.
- OCW3 decode:
  - din[1]=1: rd_sel=din[0].
  - din[6]=1: smm=din[5].
  - Poll bit din[2] is ignored.
- INTA FSM, states I_IDLE, I_WAIT2, I_VEC:
  - INTA edges are ignored unless init_done=1 and mode_err=0.
  - I_IDLE, first INTA edge:
    - Latch lvl = irq_valid ? irq_level : 7.
    - If irq_valid: isr_set_stb with isr_set_level=lvl (spurious requests never set ISR).
    - Next I_WAIT2.
  - I_WAIT2, second INTA edge:
    - vec_out={vec_base,lvl}, vec_oe=1.
    - Next I_VEC.
  - I_VEC, when synchronized ninta rises:
    - vec_oe=0.
    - If aeoi and irq_valid was latched: eoi_stb (plus rot_stb if rot_aeoi).
    - Next I_IDLE.
  - vec_out holds its value after vec_oe drops.
- Simultaneous events:
  - CPU writes and INTA edges cannot coincide functionally.
  - If an OCW2 EOI and an AEOI would pulse in the same cycle, the OCW2 strobe is issued first and the AEOI strobe one cycle later.
- Reset mid-operation returns both FSMs to the reset state immediately.

Decomposition:
- Package pic_pkg:
  - Configuration and INTA state enums.
  - OCW2 command codes (3 bits).
  - ICW/OCW field bit-position constants.
  - Strobe-width constant.
- Sub-module pic_strobe_sync (parameter SYNC_STAGES):
  - Synchronizer plus falling/rising edge detect.
  - Instantiated twice: write strobe and ninta.

Test Plan:
- Reset, then ICW1=0x13, ICW2=0x48 (a0=1), ICW4=0x01 -> ICW3 skipped; vec_base=5'h09, ltim=0, sngl=1, init_done=1, imr=0x00, mode_err=0.
- ICW1=0x11, ICW2=0x20, ICW3=0x04, ICW4=0x03 -> cas_cfg=0x04, aeoi=1; OCW1 0xF0 -> imr=0xF0.
- In S_READY, OCW2 0x63 -> one-cycle eoi_stb with eoi_spec=1, eoi_level=3. OCW2 0xC5 -> prio_stb, prio_level=5. OCW3 0x0B -> rd_sel=1.
- irq_valid=1, irq_level=2, vec_base=0x09, two INTA pulses -> isr_set_stb (level 2) after the first pulse; vec_oe=1 with vec_out=0x4A during the second; AEOI eoi_stb after release when aeoi=1.
- irq_valid=0 during the first INTA -> no isr_set_stb; vec_out={vec_base,3'd7}; no AEOI pulse.
- ICW1 written during I_WAIT2 -> vec_oe stays 0, FSM back to I_IDLE, init_done=0. Reset asserted mid-sequence -> imr=MASK_RESET and all strobes 0.
